// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - command codes, FSM states and response helpers for the SoM SPI responder
package spi_pkg;

  localparam logic [7:0] CMD_READ_SPEED = 8'h01;
  localparam logic [7:0] CMD_READ_SLICE = 8'h02;
  localparam logic [7:0] CMD_READ_ALL   = 8'h03;
  localparam logic [7:0] CMD_WRITE_CFG  = 8'h10;

  localparam int LEN_READ_SPEED = 2;
  localparam int LEN_READ_SLICE = 1;
  localparam int LEN_READ_ALL   = 3;

  typedef enum logic [2:0] {IDLE, CMD, RESP, WR, DONE} spi_state_t;

  // Number of response bits for a command; zero means "not a read".
  function automatic logic [4:0] resp_bits(input logic [7:0] cmd);
    case (cmd)
      CMD_READ_SPEED: return 5'(LEN_READ_SPEED * 8);
      CMD_READ_SLICE: return 5'(LEN_READ_SLICE * 8);
      CMD_READ_ALL:   return 5'(LEN_READ_ALL * 8);
      default:        return 5'd0;
    endcase
  endfunction

  // Response bits left-aligned in the 24-bit shift register, zero padded.
  function automatic logic [23:0] resp_word(input logic [7:0] cmd,
                                            input logic [15:0] speed,
                                            input logic [7:0] slice);
    case (cmd)
      CMD_READ_SPEED: return {speed, 8'h00};
      CMD_READ_SLICE: return {slice, 16'h0000};
      CMD_READ_ALL:   return {speed, slice};
      default:        return 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - synchronizers and edge pulses for the SPI pins
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic cs,
  input  logic sclk,
  input  logic mosi,
  output logic cs_fall,
  output logic cs_rise,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   cs_prev;
  logic                   sclk_prev;
  logic                   cs_now;
  logic                   sclk_now;

  // cs resets high so a deasserted pin produces no edge when reset releases.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_prev   <= 1'b1;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_prev   <= cs_sync[SYNC_STAGES-1];
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign cs_now    = cs_sync[SYNC_STAGES-1];
  assign sclk_now  = sclk_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_prev & ~cs_now;
  assign cs_rise   = ~cs_prev & cs_now;
  assign sclk_rise = ~sclk_prev & sclk_now & ~cs_now;
  assign sclk_fall = sclk_prev & ~sclk_now & ~cs_now;
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/som_spi_responder.sv
// rtl/som_spi_responder.sv - SPI mode-0 responder exposing hall-sensor data and a config word to the SoM
import spi_pkg::*;

module som_spi_responder #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        som_cs,
  input  logic        som_sclk,
  input  logic        som_mosi,
  output logic        som_miso,
  input  logic [15:0] speed_data,
  input  logic [7:0]  slice_cnt,
  output logic [15:0] cfg_data,
  output logic        cfg_valid,
  output logic        cmd_err
);

  logic        cs_fall, cs_rise, sclk_rise, sclk_fall, mosi_s;
  spi_state_t  state_q, state_d;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [6:0]  cmd_sr;
  logic [7:0]  cmd_byte;
  logic [23:0] resp_sr;
  logic [4:0]  resp_left;
  logic [14:0] wr_sr;
  logic        last_bit;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .nrst      (nrst),
    .cs        (som_cs),
    .sclk      (som_sclk),
    .mosi      (som_mosi),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .mosi_s    (mosi_s)
  );

  assign cmd_byte = {cmd_sr, mosi_s};
  assign last_bit = sclk_rise && (bit_cnt == 3'd7);

  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = IDLE;
    end else if (cs_fall) begin
      state_d = CMD;
    end else begin
      case (state_q)
        CMD: begin
          if (last_bit) begin
            if (cmd_byte == CMD_WRITE_CFG)          state_d = WR;
            else if (resp_bits(cmd_byte) != 5'd0)   state_d = RESP;
            else                                    state_d = DONE;
          end
        end
        RESP:    if (sclk_fall && resp_left == 5'd0)        state_d = DONE;
        WR:      if (last_bit && byte_cnt == 2'd2)          state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      bit_cnt   <= 3'd0;
      byte_cnt  <= 2'd0;
      cmd_sr    <= 7'd0;
      resp_sr   <= 24'd0;
      resp_left <= 5'd0;
      wr_sr     <= 15'd0;
      som_miso  <= IDLE_MISO;
      cfg_data  <= 16'h0000;
      cfg_valid <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_valid <= 1'b0;
      cmd_err   <= 1'b0;
      if (cs_rise || cs_fall) begin
        bit_cnt  <= 3'd0;
        byte_cnt <= 2'd0;
        som_miso <= IDLE_MISO;
      end else begin
        if (sclk_rise && state_q != IDLE) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7 && byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
        end
        case (state_q)
          CMD: begin
            if (sclk_rise) cmd_sr <= cmd_byte[6:0];
            // Snapshot both measurements together so a frame is self-consistent.
            if (last_bit) begin
              resp_sr   <= resp_word(cmd_byte, speed_data, slice_cnt);
              resp_left <= resp_bits(cmd_byte);
              cmd_err   <= (cmd_byte != CMD_WRITE_CFG) && (resp_bits(cmd_byte) == 5'd0);
            end
          end
          RESP: begin
            if (sclk_fall) begin
              if (resp_left != 5'd0) begin
                som_miso  <= resp_sr[23];
                resp_sr   <= {resp_sr[22:0], 1'b0};
                resp_left <= resp_left - 5'd1;
              end else begin
                som_miso  <= IDLE_MISO;
              end
            end
          end
          WR: begin
            if (sclk_rise) wr_sr <= {wr_sr[13:0], mosi_s};
            if (last_bit && byte_cnt == 2'd2) begin
              cfg_data  <= {wr_sr, mosi_s};
              cfg_valid <= 1'b1;
            end
          end
          default: som_miso <= IDLE_MISO;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_som_spi_responder.sv
// tb/tb_som_spi_responder.sv - directed bench acting as the SoM SPI initiator
module tb_som_spi_responder;

  logic        clk = 1'b0;
  logic        nrst;
  logic        som_cs, som_sclk, som_mosi;
  logic        som_miso;
  logic [15:0] speed_data;
  logic [7:0]  slice_cnt;
  logic [15:0] cfg_data;
  logic        cfg_valid, cmd_err;

  int vectors = 0;
  int errors  = 0;
  int cyc = 0;
  int last_rise = 0;
  int valid_cnt = 0;
  int valid_cyc = 0;
  int err_cnt = 0;

  som_spi_responder dut (
    .clk        (clk),
    .nrst       (nrst),
    .som_cs     (som_cs),
    .som_sclk   (som_sclk),
    .som_mosi   (som_mosi),
    .som_miso   (som_miso),
    .speed_data (speed_data),
    .slice_cnt  (slice_cnt),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cfg_valid) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
    end
    if (cmd_err) err_cnt = err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clocks nbits of tx out MSB first at clk/8; rx holds what was sampled at each rise.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      som_sclk = 1'b0;
      som_mosi = tx[i];
      tick(4);
      rx[i] = som_miso;
      som_sclk = 1'b1;
      last_rise = cyc;
      tick(4);
    end
  endtask

  task automatic frame_start();
    som_sclk = 1'b0;
    som_cs   = 1'b0;
    tick(6);
  endtask

  task automatic frame_end();
    som_sclk = 1'b0;
    tick(4);
    som_cs = 1'b1;
    tick(8);
  endtask

  initial begin
    logic [7:0] rx;
    int v0, e0;

    nrst = 1'b0; som_cs = 1'b1; som_sclk = 1'b0; som_mosi = 1'b0;
    speed_data = 16'hA55A; slice_cnt = 8'h07;
    tick(3);
    check("rst_miso", 32'(som_miso), 32'h0);
    check("rst_cfg_data", 32'(cfg_data), 32'h0);
    check("rst_cfg_valid", 32'(cfg_valid), 32'h0);
    check("rst_cmd_err", 32'(cmd_err), 32'h0);
    nrst = 1'b1;
    tick(4);

    // READ_SPEED
    e0 = err_cnt;
    frame_start();
    xfer(8'h01, 8, rx); check("rs_cmd_miso", 32'(rx), 32'h00);
    xfer(8'h00, 8, rx); check("rs_b0", 32'(rx), 32'hA5);
    xfer(8'h00, 8, rx); check("rs_b1", 32'(rx), 32'h5A);
    frame_end();
    check("rs_no_err", 32'(err_cnt - e0), 32'h0);

    // READ_ALL with speed changing after the command byte
    speed_data = 16'h1234;
    frame_start();
    xfer(8'h03, 8, rx);
    speed_data = 16'hFFFF;
    xfer(8'h00, 8, rx); check("ra_b0", 32'(rx), 32'h12);
    xfer(8'h00, 8, rx); check("ra_b1", 32'(rx), 32'h34);
    xfer(8'h00, 8, rx); check("ra_b2", 32'(rx), 32'h07);
    xfer(8'h00, 8, rx); check("ra_extra", 32'(rx), 32'h00);
    frame_end();

    // WRITE_CFG 0xBEEF
    v0 = valid_cnt;
    frame_start();
    xfer(8'h10, 8, rx);
    xfer(8'hBE, 8, rx);
    xfer(8'hEF, 8, rx);
    frame_end();
    check("wr_cfg_data", 32'(cfg_data), 32'hBEEF);
    check("wr_valid_pulses", 32'(valid_cnt - v0), 32'h1);
    check("wr_valid_latency", 32'(valid_cyc - last_rise), 32'h3);

    // Aborted write: 0xCA then half a byte
    v0 = valid_cnt;
    frame_start();
    xfer(8'h10, 8, rx);
    xfer(8'hCA, 8, rx);
    xfer(8'h5F, 4, rx);
    frame_end();
    check("abort_no_valid", 32'(valid_cnt - v0), 32'h0);
    check("abort_cfg_kept", 32'(cfg_data), 32'hBEEF);
    slice_cnt = 8'h3C;
    frame_start();
    xfer(8'h02, 8, rx);
    xfer(8'h00, 8, rx); check("slice_b0", 32'(rx), 32'h3C);
    xfer(8'h00, 8, rx); check("slice_extra", 32'(rx), 32'h00);
    frame_end();

    // Unknown command
    e0 = err_cnt;
    frame_start();
    xfer(8'h55, 8, rx);
    xfer(8'h00, 8, rx); check("bad_b0", 32'(rx), 32'h00);
    xfer(8'h00, 8, rx); check("bad_b1", 32'(rx), 32'h00);
    frame_end();
    check("bad_err_pulses", 32'(err_cnt - e0), 32'h1);

    // Reset in the middle of a READ_SPEED response
    speed_data = 16'hA55A;
    frame_start();
    xfer(8'h01, 8, rx);
    som_sclk = 1'b0;
    tick(4);
    check("pre_rst_miso", 32'(som_miso), 32'h1);
    #2 nrst = 1'b0;
    #1;
    check("mid_rst_miso", 32'(som_miso), 32'h0);
    check("mid_rst_cfg", 32'(cfg_data), 32'h0);
    som_cs = 1'b1;
    tick(2);
    nrst = 1'b1;
    tick(4);
    frame_start();
    xfer(8'h01, 8, rx);
    xfer(8'h00, 8, rx); check("post_rst_b0", 32'(rx), 32'hA5);
    xfer(8'h00, 8, rx); check("post_rst_b1", 32'(rx), 32'h5A);
    frame_end();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
